// File: rtl/mc_control_pkg.sv
// mc_control_pkg: state codes, opcodes, datapath select encodings and per-state control decode
package mc_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BREX   = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OPC   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Moore controls owned by a state; fetch and brEx are later qualified by memReady / opcode
  typedef struct packed {
    logic       fetch;
    logic       brEx;
    logic       pcWrite;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic       memToReg;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
  } ctrl_t;

  function automatic ctrl_t ctrlOf(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch   = 1'b1;
        c.memRead = 1'b1;
        c.aluSrcB = SRCB_FOUR;
      end
      DECODE: c.aluSrcB = SRCB_IMMSH;
      MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
      end
      MEMRD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      MEMWB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
      end
      MEMWR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      REX: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = ALU_FUNCT;
      end
      RWB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      BREX: begin
        c.brEx    = 1'b1;
        c.aluSrcA = 1'b1;
        c.aluOp   = ALU_SUB;
        c.pcSrc   = PC_ALUOUT;
      end
      IMMEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_OPC;
      end
      IMMWB: c.regWrite = 1'b1;
      JEX: begin
        c.pcWrite = 1'b1;
        c.pcSrc   = PC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: memory handshake between the controller and the memory port
interface mc_control_if;
  logic i_memReady;
  logic o_memRead;
  logic o_memWrite;
  logic o_iorD;
  modport master (input i_memReady, output o_memRead, o_memWrite, o_iorD);
  modport slave (output i_memReady, input o_memRead, o_memWrite, o_iorD);
endinterface

// File: rtl/mc_control_op_class.sv
// mc_op_class: combinational opcode classification for the decode state
module mc_op_class
  import mc_control_pkg::*;
#(
  parameter int EN_BNE = 1
) (
  input  logic [5:0] instrCode,
  output logic       is_mem,
  output logic       is_r,
  output logic       is_br,
  output logic       is_j,
  output logic       is_imm,
  output logic       is_illegal
);
  assign is_mem     = instrCode inside {OP_LW, OP_SW};
  assign is_r       = instrCode == OP_RTYPE;
  assign is_br      = instrCode == OP_BEQ || (EN_BNE != 0 && instrCode == OP_BNE);
  assign is_j       = instrCode == OP_J;
  assign is_imm     = instrCode inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI};
  assign is_illegal = !(is_mem || is_r || is_br || is_j || is_imm);
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle processor control FSM with retired-instruction counter
module mc_control
  import mc_control_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int EN_BNE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_instrCode,
  mc_control_if.master     mem,
  output logic             o_pcWrite,
  output logic             o_branch,
  output logic             o_branchNe,
  output logic             o_irWrite,
  output logic             o_memToReg,
  output logic             o_regDst,
  output logic             o_regWrite,
  output logic             o_aluSrcA,
  output logic             o_extOp,
  output logic             o_illegal,
  output logic [1:0]       o_aluSrcB,
  output logic [1:0]       o_aluOp,
  output logic [1:0]       o_pcSrc,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_instrCount
);
  state_t state, nextState;
  ctrl_t  ctrl;
  logic   isMem, isR, isBr, isJ, isImm, isIllegal;
  logic   retire;
  logic   memReady;

  assign memReady = mem.i_memReady;

  mc_op_class #(.EN_BNE(EN_BNE)) u_opClass (
    .instrCode  (i_instrCode),
    .is_mem     (isMem),
    .is_r       (isR),
    .is_br      (isBr),
    .is_j       (isJ),
    .is_imm     (isImm),
    .is_illegal (isIllegal)
  );

  // next-state selection; undefined codes and illegal opcodes fall back to FETCH
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:   nextState = memReady ? DECODE : FETCH;
      DECODE:  nextState = isMem ? MEMADR : isR ? REX : isBr ? BREX : isJ ? JEX : isImm ? IMMEX : FETCH;
      MEMADR:  nextState = (i_instrCode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nextState = memReady ? MEMWB : MEMRD;
      MEMWR:   nextState = memReady ? FETCH : MEMWR;
      REX:     nextState = RWB;
      IMMEX:   nextState = IMMWB;
      default: nextState = FETCH;
    endcase
  end

  // an instruction retires on the final-state return to FETCH; illegal returns come from DECODE and never count
  assign retire = state inside {MEMWB, RWB, BREX, JEX, IMMWB} || (state == MEMWR && memReady);

  // state, registered per-state controls and the retired-instruction counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= FETCH;
      ctrl         <= ctrlOf(FETCH);
      o_instrCount <= '0;
    end else begin
      state <= nextState;
      ctrl  <= ctrlOf(nextState);
      if (retire) o_instrCount <= o_instrCount + CNT_W'(1);
    end
  end

  assign o_state        = state;
  assign o_pcWrite      = i_rst_n && (ctrl.pcWrite || (ctrl.fetch && memReady));
  assign o_irWrite      = i_rst_n && ctrl.fetch && memReady;
  assign mem.o_memRead  = i_rst_n && ctrl.memRead;
  assign mem.o_memWrite = i_rst_n && ctrl.memWrite;
  assign mem.o_iorD     = ctrl.iorD;
  assign o_regWrite     = i_rst_n && ctrl.regWrite;
  assign o_branch       = i_rst_n && ctrl.brEx && i_instrCode == OP_BEQ;
  assign o_branchNe     = i_rst_n && ctrl.brEx && i_instrCode == OP_BNE;
  assign o_illegal      = i_rst_n && state == DECODE && isIllegal;
  assign o_memToReg     = ctrl.memToReg;
  assign o_regDst       = ctrl.regDst;
  assign o_aluSrcA      = ctrl.aluSrcA;
  assign o_aluSrcB      = ctrl.aluSrcB;
  assign o_aluOp        = ctrl.aluOp;
  assign o_pcSrc        = ctrl.pcSrc;
  assign o_extOp        = !(i_instrCode inside {OP_ANDI, OP_ORI});
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven check of the control FSM plus counter-wrap and EN_BNE=0 sequences
module tb_mc_control;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ORI = 6'b001101, ADDI = 6'b001000, BAD = 6'b111111;
  localparam logic [12:0] PCW = 13'h1000, BR = 13'h0800, BN = 13'h0400, IORD = 13'h0200, MRD = 13'h0100;
  localparam logic [12:0] MWR = 13'h0080, IRW = 13'h0040, M2R = 13'h0020, RDST = 13'h0010, RWR = 13'h0008;
  localparam logic [12:0] SRCA = 13'h0004, EXT = 13'h0002, ILL = 13'h0001;
  localparam logic [12:0] FR = MRD | IRW | PCW;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [12:0] str;
    logic [1:0]  sb;
    logic [1:0]  ao;
    logic [1:0]  ps;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, memReady = 1'b0;
  logic [5:0] instrCode = 6'd0;
  int compared = 0, mismatched = 0;

  mc_control_if memA ();
  mc_control_if memB ();
  assign memA.i_memReady = memReady;
  assign memB.i_memReady = memReady;

  logic aPcW, aBr, aBn, aIrW, aM2R, aRdst, aRw, aSrcA, aExt, aIll;
  logic [1:0] aSrcB, aAluOp, aPcSrc;
  logic [3:0] aState;
  logic [31:0] aCnt;
  logic bPcW, bBr, bBn, bIrW, bM2R, bRdst, bRw, bSrcA, bExt, bIll;
  logic [1:0] bSrcB, bAluOp, bPcSrc;
  logic [3:0] bState;
  logic [3:0] bCnt;

  mc_control dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_instrCode(instrCode), .mem(memA),
    .o_pcWrite(aPcW), .o_branch(aBr), .o_branchNe(aBn), .o_irWrite(aIrW), .o_memToReg(aM2R),
    .o_regDst(aRdst), .o_regWrite(aRw), .o_aluSrcA(aSrcA), .o_extOp(aExt), .o_illegal(aIll),
    .o_aluSrcB(aSrcB), .o_aluOp(aAluOp), .o_pcSrc(aPcSrc), .o_state(aState), .o_instrCount(aCnt)
  );

  mc_control #(.CNT_W(4), .EN_BNE(0)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_instrCode(instrCode), .mem(memB),
    .o_pcWrite(bPcW), .o_branch(bBr), .o_branchNe(bBn), .o_irWrite(bIrW), .o_memToReg(bM2R),
    .o_regDst(bRdst), .o_regWrite(bRw), .o_aluSrcA(bSrcA), .o_extOp(bExt), .o_illegal(bIll),
    .o_aluSrcB(bSrcB), .o_aluOp(bAluOp), .o_pcSrc(bPcSrc), .o_state(bState), .o_instrCount(bCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                             input logic [12:0] str, input logic [1:0] sb, input logic [1:0] ao,
                             input logic [1:0] ps, input logic [31:0] cnt);
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.str = str;
    v.sb = sb; v.ao = ao; v.ps = ps; v.cnt = cnt;
  endfunction

  vec_t vecs[$];

  initial begin
    vecs.push_back(v(0, LW, 1, 0, EXT, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW, 1, 2, SRCA | EXT, 2'b10, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW, 1, 3, MRD | IORD | EXT, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW, 1, 4, RWR | M2R | EXT, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW, 0, 0, MRD | EXT, 2'b01, 2'b00, 2'b00, 1));
    vecs.push_back(v(1, SW, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 1));
    vecs.push_back(v(1, SW, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(v(1, SW, 1, 2, SRCA | EXT, 2'b10, 2'b00, 2'b00, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, SW, 0, 5, MWR | IORD | EXT, 2'b00, 2'b00, 2'b00, 1));
    vecs.push_back(v(1, SW, 1, 5, MWR | IORD | EXT, 2'b00, 2'b00, 2'b00, 1));
    vecs.push_back(v(1, RT, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 2));
    vecs.push_back(v(1, RT, 0, 1, EXT, 2'b11, 2'b00, 2'b00, 2));
    vecs.push_back(v(1, RT, 0, 6, SRCA | EXT, 2'b00, 2'b10, 2'b00, 2));
    vecs.push_back(v(1, RT, 0, 7, RWR | RDST | EXT, 2'b00, 2'b00, 2'b00, 2));
    vecs.push_back(v(1, BEQ, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 3));
    vecs.push_back(v(1, BEQ, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 3));
    vecs.push_back(v(1, BEQ, 1, 8, SRCA | BR | EXT, 2'b00, 2'b01, 2'b01, 3));
    vecs.push_back(v(1, BNE, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 4));
    vecs.push_back(v(1, BNE, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 4));
    vecs.push_back(v(1, BNE, 1, 8, SRCA | BN | EXT, 2'b00, 2'b01, 2'b01, 4));
    vecs.push_back(v(1, JMP, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 5));
    vecs.push_back(v(1, JMP, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 5));
    vecs.push_back(v(1, JMP, 1, 11, PCW | EXT, 2'b00, 2'b00, 2'b10, 5));
    vecs.push_back(v(1, ORI, 1, 0, FR, 2'b01, 2'b00, 2'b00, 6));
    vecs.push_back(v(1, ORI, 1, 1, 13'h0, 2'b11, 2'b00, 2'b00, 6));
    vecs.push_back(v(1, ORI, 1, 9, SRCA, 2'b10, 2'b11, 2'b00, 6));
    vecs.push_back(v(1, ORI, 1, 10, RWR, 2'b00, 2'b00, 2'b00, 6));
    vecs.push_back(v(1, ADDI, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 7));
    vecs.push_back(v(1, ADDI, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 7));
    vecs.push_back(v(1, ADDI, 1, 9, SRCA | EXT, 2'b10, 2'b11, 2'b00, 7));
    vecs.push_back(v(1, ADDI, 1, 10, RWR | EXT, 2'b00, 2'b00, 2'b00, 7));
    vecs.push_back(v(1, BAD, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 8));
    vecs.push_back(v(1, BAD, 1, 1, ILL | EXT, 2'b11, 2'b00, 2'b00, 8));
    vecs.push_back(v(1, LW, 1, 0, FR | EXT, 2'b01, 2'b00, 2'b00, 8));
    vecs.push_back(v(1, LW, 1, 1, EXT, 2'b11, 2'b00, 2'b00, 8));
    vecs.push_back(v(1, LW, 1, 2, SRCA | EXT, 2'b10, 2'b00, 2'b00, 8));
    vecs.push_back(v(1, LW, 0, 3, MRD | IORD | EXT, 2'b00, 2'b00, 2'b00, 8));
    vecs.push_back(v(0, LW, 0, 3, IORD | EXT, 2'b00, 2'b00, 2'b00, 8));
    vecs.push_back(v(0, LW, 1, 0, EXT, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW, 0, 0, MRD | EXT, 2'b01, 2'b00, 2'b00, 0));

    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst; instrCode = vecs[i].op; memReady = vecs[i].rdy;
      #1;
      check($sformatf("v%0d state", i), 32'(aState), 32'(vecs[i].st));
      check($sformatf("v%0d strobes", i),
            32'({aPcW, aBr, aBn, memA.o_iorD, memA.o_memRead, memA.o_memWrite, aIrW, aM2R, aRdst, aRw, aSrcA, aExt, aIll}),
            32'(vecs[i].str));
      check($sformatf("v%0d aluSrcB", i), 32'(aSrcB), 32'(vecs[i].sb));
      check($sformatf("v%0d aluOp", i), 32'(aAluOp), 32'(vecs[i].ao));
      check($sformatf("v%0d pcSrc", i), 32'(aPcSrc), 32'(vecs[i].ps));
      check($sformatf("v%0d count", i), aCnt, vecs[i].cnt);
    end

    @(negedge clk);
    rst_n = 1'b0; memReady = 1'b1; instrCode = JMP;
    @(negedge clk);
    #1;
    check("jrst countA", aCnt, 32'd0);
    check("jrst countB", 32'(bCnt), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("j%0d stateB", k), 32'(bState), 32'd11);
      check($sformatf("j%0d pcWriteB", k), 32'(bPcW), 32'd1);
      check($sformatf("j%0d pcSrcB", k), 32'(bPcSrc), 32'd2);
      @(negedge clk);
      #1;
      check($sformatf("j%0d countB", k), 32'(bCnt), 32'((k + 1) % 16));
      check($sformatf("j%0d countA", k), aCnt, 32'(k + 1));
    end

    instrCode = BNE;
    @(negedge clk);
    #1;
    check("bne0 stateA", 32'(aState), 32'd1);
    check("bne0 stateB", 32'(bState), 32'd1);
    check("bne0 illegalA", 32'(aIll), 32'd0);
    check("bne0 illegalB", 32'(bIll), 32'd1);
    @(negedge clk);
    #1;
    check("bne0 nextA", 32'(aState), 32'd8);
    check("bne0 branchNeA", 32'(aBn), 32'd1);
    check("bne0 nextB", 32'(bState), 32'd0);
    check("bne0 countB", 32'(bCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
